// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier, W x W -> 2W, signed/unsigned; SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN finishes once the multiplier is exhausted.
// Latency W/N+1 edges after accept (shorter with early exit); commands are taken only while out_can_accept_cmd=1.
module shift_add_multiplier #(
  parameter int ARGS_WIDTH               = 32,
  parameter int NUM_ITERATIONS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_enable,
  input  logic                  in_unsgn_or_sgn,
  input  logic [ARGS_WIDTH-1:0] in_a,
  input  logic [ARGS_WIDTH-1:0] in_b,
  output logic [ARGS_WIDTH-1:0] out_prod_hi,
  output logic [ARGS_WIDTH-1:0] out_prod_lo,
  output logic                  out_can_accept_cmd,
  output logic                  out_data_ready
);

  localparam int W     = ARGS_WIDTH;
  localparam int N     = NUM_ITERATIONS_PER_CYCLE;
  localparam int STEPS = W / N;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            sign_diff_q, sign_diff_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic            can_accept_q, can_accept_d;
  logic            ready_q, ready_d;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [2*W-1:0]  step_acc, step_mc;
  logic [W-1:0]    step_mp;
  logic [2*W-1:0]  final_prod;

  // Magnitudes are plain W-bit unsigned, so -2^(W-1) maps to 2^(W-1) exactly.
  assign a_neg = in_unsgn_or_sgn & in_a[W-1];
  assign b_neg = in_unsgn_or_sgn & in_b[W-1];
  assign a_mag = a_neg ? (~in_a + 1'b1) : in_a;
  assign b_mag = b_neg ? (~in_b + 1'b1) : in_b;

  assign final_prod = (mode_q && sign_diff_q) ? (~acc_q + 1'b1) : acc_q;

  // N multiplier bits per edge; the multiplicand is pre-shifted so each bit adds it in place.
  always_comb begin
    step_acc = acc_q;
    step_mc  = mcand_q;
    step_mp  = mplier_q;
    for (int i = 0; i < N; i++) begin
      if (step_mp[0]) begin
        step_acc = step_acc + step_mc;
      end
      step_mc = step_mc << 1;
      step_mp = step_mp >> 1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    sign_diff_d  = sign_diff_q;
    prod_d       = prod_q;
    can_accept_d = can_accept_q;
    ready_d      = ready_q;

    case (state_q)
      S_IDLE: begin
        if (in_enable && can_accept_q) begin
          mcand_d      = {{W{1'b0}}, a_mag};
          mplier_d     = b_mag;
          acc_d        = '0;
          cnt_d        = CW'(STEPS);
          mode_d       = in_unsgn_or_sgn;
          sign_diff_d  = a_neg ^ b_neg;
          can_accept_d = 1'b0;
          ready_d      = 1'b0;
          state_d      = S_ITER;
        end
      end

      S_ITER: begin
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        if (mplier_q == '0) begin
          prod_d       = final_prod;
          can_accept_d = 1'b1;
          ready_d      = 1'b1;
          state_d      = S_IDLE;
        end else begin
`else
        begin
`endif
          acc_d    = step_acc;
          mcand_d  = step_mc;
          mplier_d = step_mp;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        prod_d       = final_prod;
        can_accept_d = 1'b1;
        ready_d      = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      sign_diff_q  <= 1'b0;
      prod_q       <= '0;
      can_accept_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      sign_diff_q  <= sign_diff_d;
      prod_q       <= prod_d;
      can_accept_q <= can_accept_d;
      ready_q      <= ready_d;
    end
  end

  assign out_prod_hi        = prod_q[2*W-1:W];
  assign out_prod_lo        = prod_q[W-1:0];
  assign out_can_accept_cmd = can_accept_q;
  assign out_data_ready     = ready_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed vectors for shift_add_multiplier; expected products and latencies are queued at issue
// and a negedge monitor pops and compares on every rising out_data_ready.
module tb_shift_add_multiplier;

  localparam int W = 32;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_enable;
  logic         in_sgn;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] hi, lo;
  logic         can_acc, rdy;

  shift_add_multiplier #(.ARGS_WIDTH(W), .NUM_ITERATIONS_PER_CYCLE(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_enable          (in_enable),
    .in_unsgn_or_sgn    (in_sgn),
    .in_a               (in_a),
    .in_b               (in_b),
    .out_prod_hi        (hi),
    .out_prod_lo        (lo),
    .out_can_accept_cmd (can_acc),
    .out_data_ready     (rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           acc_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;
  logic prev_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Edges from accept to result: W+1 fixed, or up to the top set multiplier bit with early exit.
  function automatic int exp_lat(input logic sgn, input logic [W-1:0] b);
    logic [W-1:0] m;
    int hb;
    m  = (sgn && b[W-1]) ? (~b + 1'b1) : b;
    hb = -1;
    for (int i = 0; i < W; i++) if (m[i]) hb = i;
    return EARLY ? ((hb < 0) ? 1 : hb + 2) : W + 1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_rdy <= 1'b0;
    end else begin
      if (rdy && !prev_rdy) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got hi=0x%0h lo=0x%0h, expected no result", hi, lo);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
          check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
          check({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
        end
      end
      prev_rdy <= rdy;
    end
  end

  // Waits for an idle unit, presents the command for one accept edge and queues its expectation.
  task automatic issue(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!can_acc && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!can_acc) begin
      total++;
      $display("FAIL %s_accept_timeout: can_accept=0 after 200 cycles, expected 1", name);
      return;
    end
    in_sgn    = sgn;
    in_a      = a;
    in_b      = b;
    in_enable = 1'b1;
    sb.push_back('{hi_e, lo_e, exp_lat(sgn, b), cyc + 1, name});
    @(negedge clk);
    if (!hold) in_enable = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_can_accept"}, 64'(can_acc), 64'd1);
    check({name, "_ready"},      64'(rdy),     64'd0);
    check({name, "_hi"},         64'(hi),      64'd0);
    check({name, "_lo"},         64'(lo),      64'd0);
  endtask

  initial begin
    int busy;
    int waited;
    rst = 1'b1; in_enable = 1'b0; in_sgn = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");

    issue("u_7x6",      1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0);
    issue("u_max_sq",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue("s_m1_sq",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    issue("s_min_sq",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    issue("s_m3x5",     1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue("s_maxxmin",  1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0);

    // Enable stays high with scrambled operands through the busy period, FINISH cycle included.
    issue("s_m2x3_held", 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    busy = 0;
    while (!can_acc && busy < 100) begin
      in_a   = $urandom;
      in_b   = $urandom;
      in_sgn = 1'($urandom_range(0, 1));
      @(negedge clk);
      busy++;
    end
    check("held_busy_cycles", 64'(busy), 64'(exp_lat(1'b1, 32'h0000_0003)));
    in_sgn = 1'b0; in_a = 32'h0000_0002; in_b = 32'h0000_0003;
    sb.push_back('{32'h0, 32'h6, exp_lat(1'b0, 32'h0000_0003), cyc + 1, "u_2x3_second"});
    @(negedge clk);
    in_enable = 1'b0;
    check("second_accept_ready_cleared", 64'(rdy), 64'd0);
    check("second_accept_busy", 64'(can_acc), 64'd0);

    // Abort a command mid-iteration; it must never produce a result.
    waited = 0;
    while (!can_acc && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("pre_abort_idle", 64'(can_acc), 64'd1);
    in_sgn = 1'b0; in_a = 32'd100; in_b = 32'hF000_0000; in_enable = 1'b1;
    @(negedge clk);
    in_enable = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("abort");
    issue("u_3x4_after_abort", 1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    issue("ee_x0",   1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    issue("ee_x1",   1'b0, 32'h0000_1234, 32'h0000_0001, 32'h0000_0000, 32'h0000_1234, 1'b0);
    issue("ee_xtop", 1'b0, 32'h0000_1234, 32'h8000_0000, 32'h0000_091A, 32'h0000_0000, 1'b0);
`endif

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
